// File: rtl/acum_filtro.sv
// Accumulates the signed tap products of one ADC sample and scales the sum back to N-bit Q(N-F).F.
// Optional saturation of the scaled result is enabled with the ACUM_SATURACION_EN macro.
module acum_filtro #(
  parameter int N    = 25,
  parameter int F    = 16,
  parameter int G    = 4,
  parameter int TAPS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic signed [2*N-1:0] In,
  input  logic                  ban_Adc,
  input  logic                  ban_Listo,
  output logic signed [N-1:0]   Out,
  output logic                  ban_Valido,
  output logic                  ban_Error
);

  localparam int AW = 2*N + G;
  localparam int CW = $clog2(TAPS + 1);
  localparam int RW = AW - F;

  typedef enum logic [1:0] {IDLE, ACUM, ESCALA, LISTO} state_t;

  state_t               state, state_n;
  logic signed [AW-1:0] acc, acc_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic signed [N-1:0]  out_n;
  logic                 err_n;
  logic signed [AW-1:0] in_ext;
  logic signed [RW-1:0] r;
  logic signed [N-1:0]  r_red;

  assign in_ext = {{G{In[2*N-1]}}, In};
  // Dropping the low F bits of the signed sum is a floor division by 2^F.
  assign r = acc[AW-1:F];

`ifdef ACUM_SATURACION_EN
  logic unused_bits;
  logic in_range;
  assign unused_bits = ^acc[F-1:0];
  assign in_range = (&r[RW-1:N-1]) | ~(|r[RW-1:N-1]);
  always_comb begin
    r_red = r[N-1:0];
    if (!in_range)
      r_red = r[RW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  logic unused_bits;
  assign unused_bits = ^{acc[F-1:0], r[RW-1:N]};
  assign r_red = r[N-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      Out       <= '0;
      ban_Error <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      Out       <= out_n;
      ban_Error <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    out_n   = Out;
    err_n   = ban_Error;
    unique case (state)
      IDLE: begin
        if (ban_Adc) begin
          acc_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = ACUM;
        end
      end
      ACUM: begin
        if (ban_Listo) begin
          state_n = ESCALA;
        end else begin
          acc_n = acc + in_ext;
          cnt_n = cnt + 1'b1;
          // The TAPS-th product closes the sample even without ban_Listo.
          if (cnt == CW'(TAPS - 1))
            state_n = ESCALA;
        end
      end
      ESCALA: begin
        out_n   = r_red;
        state_n = LISTO;
      end
      LISTO: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && ban_Adc)
      err_n = 1'b1;
  end

  assign ban_Valido = (state == LISTO);

endmodule

// File: tb/tb_acum_filtro.sv
// Scoreboard bench for acum_filtro: driver pushes expected results, a negedge monitor checks them.
module tb_acum_filtro;
  localparam int N    = 25;
  localparam int F    = 16;
  localparam int TAPS = 32;
  localparam longint ONE = 64'sd1 <<< 32;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic signed [2*N-1:0] in_w = '0;
  logic                  ban_adc = 1'b0;
  logic                  ban_listo = 1'b0;
  logic signed [N-1:0]   out_w;
  logic                  valido;
  logic                  error_w;

  acum_filtro #(.N(N), .F(F), .G(4), .TAPS(TAPS)) dut (
    .clk(clk), .reset_n(reset_n), .In(in_w), .ban_Adc(ban_adc), .ban_Listo(ban_listo),
    .Out(out_w), .ban_Valido(valido), .ban_Error(error_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint out; int cyc; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  longint sum;
  int     n_prod;
  bit     active, done;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, floor divide by 2^F, then clamp or wrap to N bits.
  function automatic longint ref_out(input longint s);
    longint r;
    longint lim;
    r   = s >>> F;
    lim = 64'sd1 <<< (N - 1);
`ifdef ACUM_SATURACION_EN
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
`else
    r = r & ((lim <<< 1) - 1);
    if (r >= lim) r = r - (lim <<< 1);
`endif
    return r;
  endfunction

  task automatic push(input int c);
    exp_t e;
    e.out = ref_out(sum);
    e.cyc = c + 2;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic start(input bit listo);
    ban_adc = 1'b1;
    ban_listo = listo;
    in_w = '0;
    step();
    ban_adc = 1'b0;
    ban_listo = 1'b0;
    active = 1'b1;
    done = 1'b0;
    sum = 0;
    n_prod = 0;
  endtask

  task automatic send(input longint p, input bit adc);
    int c;
    c = cyc;
    in_w = p[2*N-1:0];
    ban_adc = adc;
    if (active && !done) begin
      sum += p;
      n_prod++;
      if (n_prod == TAPS) begin
        push(c);
        done = 1'b1;
      end
    end
    step();
    ban_adc = 1'b0;
    in_w = '0;
  endtask

  task automatic finish_run();
    int c;
    c = cyc;
    ban_listo = 1'b1;
    in_w = '0;
    if (active && !done) push(c);
    active = 1'b0;
    step();
    ban_listo = 1'b0;
    idle(2);
  endtask

  always @(negedge clk) begin
    if (reset_n && valido) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got Out=%0d with no result pending (t=%0t)", out_w, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", longint'(out_w), e.out);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    active = 1'b0;
    done = 1'b0;
    idle(2);
    check("reset_out", longint'(out_w), 0);
    check("reset_valid", valido, 0);
    check("reset_error", error_w, 0);
    reset_n = 1'b1;
    idle(2);

    // Basic sum: 3 x 1.0
    start(0);
    for (int i = 0; i < 3; i++) send(ONE, 0);
    finish_run();
    check("basic_out_held", longint'(out_w), 196608);

    // Floor of a negative half value
    start(0);
    send(-(64'sd1 <<< 31), 0);
    send(64'sd1 <<< 15, 0);
    finish_run();
    check("neg_floor_held", longint'(out_w), -32768);

    // Overflow of the N-bit range
    start(0);
    for (int i = 0; i < 3; i++) send(100 * ONE, 0);
    finish_run();
`ifdef ACUM_SATURACION_EN
    check("overflow_held", longint'(out_w), 16777215);
`else
    check("overflow_held", longint'(out_w), -13893632);
`endif

    // TAPS hard stop, ban_Listo never raised
    start(0);
    for (int i = 0; i < 40; i++) send(ONE, 0);
    idle(2);
    check("taps_limit_held", longint'(out_w), 2097152);

    // Zero products
    start(0);
    finish_run();
    check("zero_products_held", longint'(out_w), 0);

    // ban_Adc mid-ACUM: sum unaffected, error set and sticky
    start(0);
    send(ONE, 0);
    send(ONE, 1);
    check("error_set", error_w, 1);
    send(ONE, 0);
    finish_run();
    idle(3);
    check("error_sticky", error_w, 1);
    check("error_run_out", longint'(out_w), 196608);

    // ban_Adc and ban_Listo together in IDLE: ACUM entered, error cleared
    start(1);
    check("error_cleared", error_w, 0);
    send(2 * ONE, 0);
    finish_run();
    check("adc_listo_out", longint'(out_w), 131072);

    // Async reset mid-ACUM after 2 adds
    start(0);
    send(ONE, 0);
    send(ONE, 0);
    active = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_out", longint'(out_w), 0);
    check("async_reset_valid", valido, 0);
    check("async_reset_error", error_w, 0);
    #4 reset_n = 1'b1;
    idle(3);
    start(0);
    send(ONE, 0);
    finish_run();
    check("after_reset_out", longint'(out_w), 65536);

    // Randomized runs, some beyond the TAPS limit
    for (int r = 0; r < 25; r++) begin
      int k;
      k = $urandom_range(0, 36);
      start(0);
      for (int i = 0; i < k; i++) begin
        longint p;
        p = longint'($signed($urandom)) <<< $urandom_range(0, 17);
        send(p, 0);
      end
      finish_run();
      idle($urandom_range(0, 3));
    end

    idle(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
